rd_addr_ctrl: RTL

//  Read-side counterpart of the capture write controller. After a capture completes
//  (tri_done=1), it reads the capture RAM in chronological order. It starts at

---
 rtl/rd_addr_ctrl_pkg.sv | 17 +
 rtl/rd_stream_fifo.sv | 68 ++++++
 rtl/rd_addr_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rd_addr_ctrl_pkg.sv
// Shared definitions for the capture readout controller: FSM state
// encoding and the supported RAM read latency range.
package rd_addr_ctrl_pkg;

   // Readout FSM states (2-bit encoding shared with the debug readout path)
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_e;

   // RAM read latency supported by the valid shift register
   localparam int RAM_RD_LAT_MIN = 1;
   localparam int RAM_RD_LAT_MAX = 3;

endpackage

// File: rtl/rd_stream_fifo.sv
// Synchronous show-ahead FIFO for the readout stream. The head word is
// visible on rd_data whenever vld is high; flush empties it in one cycle.
module rd_stream_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             vld,
   output logic [PW:0]      count
);

   localparam logic [PW:0] PTR_ONE = 1;
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_fire;
   logic             rd_fire;
   logic             full;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign vld     = (count != '0);
   assign full    = (count == FULL_COUNT);
   assign wr_fire = wr_en && !flush;
   assign rd_fire = rd_en && vld && !flush;
   assign rd_data = mem[rd_ptr_q[PW-1:0]];

   // Pointer update; a flush discards everything, including a same-cycle write
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // Pointer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr_q[PW-1:0]] <= wr_data;
   end

   // The upstream credit scheme must never push into a full FIFO
   assert property (@(posedge clk) disable iff (rst) !(wr_fire && full && !rd_fire));

endmodule

// File: rtl/rd_addr_ctrl.sv
// Capture RAM readout controller. Once a capture is complete it reads the
// RAM oldest-first, wrapping at capture_max_addr, and streams the words out
// on a valid/ready interface, pulsing tri_done_rd when the last word leaves.
module rd_addr_ctrl
   import rd_addr_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 14,
   parameter int RAM_RD_LAT = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_start,
   input  logic                  rd_abort,
   input  logic                  tri_done,
   input  logic [ADDR_WIDTH-1:0] read_start_addr,
   input  logic [ADDR_WIDTH-1:0] capture_max_addr,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_vld,
   input  logic                  rd_data_rdy,
   output logic                  rd_last,
   output logic                  rd_busy,
   output logic                  tri_done_rd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;
   localparam logic [CW:0]           CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

   rd_state_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH-1:0]   max_q, max_d;
   logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
   logic [CW-1:0]           inflight_q, inflight_d;
   logic                    ram_rd_en_q, ram_rd_en_d;
   logic [ADDR_WIDTH-1:0]   ram_rd_addr_q, ram_rd_addr_d;
   logic                    ram_last_q, ram_last_d;
   logic [RAM_RD_LAT-1:0]   vld_sr_q, vld_sr_d;
   logic [RAM_RD_LAT-1:0]   last_sr_q, last_sr_d;

   logic [ADDR_WIDTH-1:0]   start_addr;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [ADDR_WIDTH-1:0]   cur_max;
   logic [ADDR_WIDTH:0]     cur_rem;
   logic                    try_issue;
   logic                    issue;
   logic                    abort_now;
   logic                    credit_ok;
   logic [CW:0]             credit_used;
   logic                    exit_vld;
   logic                    last_pop;

   logic [CW-1:0]           fifo_count;
   logic                    fifo_vld;
   logic [DATA_WIDTH:0]     fifo_rd_data;

   assign abort_now   = rd_abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
   assign credit_ok   = (credit_used < CREDIT_LIMIT);
   assign exit_vld    = vld_sr_q[RAM_RD_LAT-1];
   assign last_pop    = fifo_vld && rd_data_rdy && fifo_rd_data[DATA_WIDTH];
   assign start_addr  = (read_start_addr > capture_max_addr) ? '0 : read_start_addr;

   // Next-state, address/remaining counters, credit and latency tracking.
   // The first read is issued in the start cycle itself so that ram_rd_en
   // rises one cycle after rd_start; the start cycle therefore loads the
   // counters with the first issue already applied.
   always_comb begin
      state_d       = state_q;
      rd_addr_d     = rd_addr_q;
      max_d         = max_q;
      remaining_d   = remaining_q;
      ram_rd_en_d   = 1'b0;
      ram_rd_addr_d = ram_rd_addr_q;
      ram_last_d    = 1'b0;
      vld_sr_d      = RAM_RD_LAT'({vld_sr_q, ram_rd_en_q});
      last_sr_d     = RAM_RD_LAT'({last_sr_q, ram_last_q});
      cur_addr      = rd_addr_q;
      cur_max       = max_q;
      cur_rem       = remaining_q;
      try_issue     = 1'b0;
      issue         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rd_start && tri_done && !rd_abort) begin
               cur_addr  = start_addr;
               cur_max   = capture_max_addr;
               cur_rem   = {1'b0, capture_max_addr} + REM_ONE;
               try_issue = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (rd_abort) state_d = ST_IDLE;
            else          try_issue = 1'b1;
         end
         ST_DRAIN: begin
            if (rd_abort)      state_d = ST_IDLE;
            else if (last_pop) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (try_issue) begin
         max_d       = cur_max;
         rd_addr_d   = cur_addr;
         remaining_d = cur_rem;
         if (credit_ok) begin
            issue         = 1'b1;
            ram_rd_en_d   = 1'b1;
            ram_rd_addr_d = cur_addr;
            rd_addr_d     = (cur_addr == cur_max) ? '0 : cur_addr + ADDR_ONE;
            remaining_d   = cur_rem - REM_ONE;
            ram_last_d    = (cur_rem == REM_ONE);
            if (cur_rem == REM_ONE) state_d = ST_DRAIN;
         end
      end

      if (abort_now) begin
         vld_sr_d   = '0;
         last_sr_d  = '0;
         inflight_d = '0;
      end else begin
         inflight_d = inflight_q + CW'(issue) - CW'(exit_vld);
      end
   end

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         rd_addr_q     <= '0;
         max_q         <= '0;
         remaining_q   <= '0;
         inflight_q    <= '0;
         ram_rd_en_q   <= 1'b0;
         ram_rd_addr_q <= '0;
         ram_last_q    <= 1'b0;
         vld_sr_q      <= '0;
         last_sr_q     <= '0;
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         max_q         <= max_d;
         remaining_q   <= remaining_d;
         inflight_q    <= inflight_d;
         ram_rd_en_q   <= ram_rd_en_d;
         ram_rd_addr_q <= ram_rd_addr_d;
         ram_last_q    <= ram_last_d;
         vld_sr_q      <= vld_sr_d;
         last_sr_q     <= last_sr_d;
      end
   end

   rd_stream_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort_now),
      .wr_en   (exit_vld),
      .wr_data ({last_sr_q[RAM_RD_LAT-1], ram_rd_data}),
      .rd_en   (rd_data_rdy),
      .rd_data (fifo_rd_data),
      .vld     (fifo_vld),
      .count   (fifo_count)
   );

   assign ram_rd_en   = ram_rd_en_q;
   assign ram_rd_addr = ram_rd_addr_q;
   assign rd_data_vld = fifo_vld;
   assign rd_data     = fifo_vld ? fifo_rd_data[DATA_WIDTH-1:0] : '0;
   assign rd_last     = fifo_vld && fifo_rd_data[DATA_WIDTH];
   assign rd_busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign tri_done_rd = (state_q == ST_DONE);

   // Configuration sanity: latency within the shift register range and a
   // power-of-two FIFO large enough to cover the read pipeline
   assert property (@(posedge clk)
      (RAM_RD_LAT >= RAM_RD_LAT_MIN) && (RAM_RD_LAT <= RAM_RD_LAT_MAX) &&
      (FIFO_DEPTH >= RAM_RD_LAT + 1) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0));

endmodule
